// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART definitions: 8N1 frame constants and the transmit-buffer offer states.
// The baud divisor stays in the global config define, not here.
package uart_tx_buffer_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a combinational head view.
// Written generically so the future RX buffer can reuse it.
module sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic [DATA_W-1:0] head
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // full/empty are the registered pre-edge view, so a push while full is
  // rejected even when a pop lands on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART transmitter over its level-sensitive ready/data pair;
// a byte is popped once the transmitter signals its last data bit has been sent.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               count,
  output logic                      overflow,
  output logic                      tx_ready,
  output logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_transmitted,
  output logic                      busy
);

  tx_state_e                 state;
  tx_state_e                 state_next;
  logic                      trans_q;
  logic                      tx_rise;
  logic                      pop;
  logic                      load;
  logic [UART_DATA_BITS-1:0] head;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // A transmitted level already high on entry to OFFER must not count as completion.
  assign tx_rise = tx_transmitted & ~trans_q;

  always_ff @(posedge clk) begin
    if (rst) trans_q <= 1'b0;
    else     trans_q <= tx_transmitted;
  end

  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // tx_data is latched once per offer and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst)       tx_data <= '0;
    else if (load) tx_data <= head;
  end

  // Completion beats a simultaneous en drop: that byte's data bits are already out.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          state_next = OFFER;
          load       = 1'b1;
        end
      end
      OFFER: begin
        if (tx_rise) begin
          pop        = 1'b1;
          state_next = IDLE;
        end else if (!en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_ready = (state == OFFER);
  assign busy     = (state == OFFER);

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO that sits directly upstream of the 8N1 UART transmitter and feeds it.
- Accepts bytes from a producer (CPU bus/debug logic) via a push strobe.
- Drives the transmitter's level-sensitive ready/data pair and pops each byte once the transmitter reports its last data bit is done.
- Keeps tx_data stable for the whole frame and allows back-to-back frames with no idle bit time.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  enable; low suspends offering to the transmitter (same signal drives the transmitter's en)
- wr_en  in  1  push strobe, one byte per cycle
- wr_data  in  8  byte to push
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  bytes held, including any byte currently being offered
- overflow  out  1  sticky: push attempted while full
- tx_ready  out  1  to transmitter ready
- tx_data  out  8  to transmitter data
- tx_transmitted  in  1  from transmitter transmitted (high from the end of data bit 7 through the stop bit)
- busy  out  1  state == OFFER

Behaviour:
- Reset values (rst high at a clk edge): state IDLE, rd/wr pointers 0, count 0, full 0, empty 1, overflow 0, tx_ready 0, tx_data 8'h00, trans_q 0. Memory contents are don't-care.
- Edge detection: trans_q <= tx_transmitted every cycle, regardless of en. tx_rise = tx_transmitted & ~trans_q.
- Push: accepted iff wr_en & ~full. The byte is written at wr_ptr, and wr_ptr wraps mod DEPTH.
  - wr_en & full: data dropped, overflow <= 1 (sticky until rst); count unchanged.
  - Push is independent of en and state.
- State IDLE: tx_ready = 0. If en & ~empty: go to OFFER; tx_data <= mem[rd_ptr] on that same edge.
- State OFFER: tx_ready = 1, and tx_data is held constant.
  - If tx_rise: pop (rd_ptr+1 mod DEPTH, count-1) and go to IDLE.
  - Else if ~en: go to IDLE with no pop. The byte is retained and re-offered from scratch once en returns.
- tx_ready is a registered state decode. It drops on the edge that samples tx_rise, while the transmitter is in its stop bit and ignoring ready.
- Next offer: in IDLE the cycle after a pop. tx_ready may rise during the stop bit; the transmitter starts the next frame when it returns to idle.
  - tx_data changing during the stop bit is legal, because the line is forced high then.
  - A high tx_transmitted that was already high on entry to OFFER is not a rise, so it never causes a pop.
- Latency:
  - wr_en at edge N into an empty FIFO gives count=1 after N, and tx_ready=1 with valid tx_data after N+1.
  - tx_rise sampled at edge M gives a pop and tx_ready=0 after M. With bytes remaining, tx_ready=1 again after M+1.
- Simultaneous push and pop in one cycle: both occur, count unchanged. full is evaluated on the pre-edge count, so a push while full is rejected even if a pop happens in the same cycle.
- count/full/empty are registered, consistent with the pointers.
- rst mid-offer: all state cleared, the queued byte is lost, tx_ready 0 on the next cycle.
- en low with tx_rise in the same cycle in OFFER: the pop takes priority, because that byte completed its data bits.

Decomposition:
- Shared UART package/header holds UART frame constants (8 data bits, 1 stop) and the state encodings IDLE=1'b0, OFFER=1'b1. The baud divisor remains the global config define.
- One natural sub-module, sync_fifo (DEPTH/width parameterised, push/pop/full/empty/count/head). It is reusable by a future RX buffer.
- The offer FSM and edge detector live in uart_tx_buffer.

Test Plan:
- Bench instantiates uart_tx_buffer driving the transmitter, with UART_CNT_FULL=9 (10 clk/bit), and a line monitor decoding uart_txd.
- Single byte: push 8'hA5 into empty at edge N, en=1 -> tx_ready=1, tx_data=8'hA5 after N+1. Line shows start, 1,0,1,0,0,1,0,1 (LSB first), stop. count 1 -> 0 at the transmitted rise; busy falls the same edge.
- Back-to-back: push 8'h01,8'h02,8'h03 in consecutive cycles -> three frames with stop bit followed immediately by next start (no extra idle bit). Exactly 3 pops; empty=1 at end.
- Fill/overflow: en=0, push DEPTH+1 bytes 8'h00..8'h10 -> full=1 after 16, count=16, overflow=1, byte 8'h10 dropped. Then en=1 -> 8'h00..8'h0F sent in order.
- Enable drop: drop en mid-frame of 8'h3C before the transmitted rise -> tx_ready=0 next cycle, count unchanged. Re-enable -> full 8'h3C frame resent.
- Simultaneous: push while a pop occurs at count=4 -> count stays 4; wrap-around verified by sending 40 sequential bytes through DEPTH=16 with matching order.
- Reset: assert rst during a data bit with count=3 -> count=0, empty=1, tx_ready=0, overflow=0 next cycle. No further frames.
